// File: rtl/enemy_lane_ctrl.sv
// rtl/enemy_lane_ctrl.sv - per-column enemy hit/hurt/death/respawn control and sprite pixel addressing
module enemy_lane_ctrl #(
  parameter int NUM_ENEMY = 4,
  parameter int HP_INIT   = 3,
  parameter int HIT_LO    = 12,
  parameter int HIT_HI    = 20,
  parameter int COL_W     = 160,
  parameter int SPR_W     = 160,
  parameter int SPR_H     = 120,
  parameter int HURT_FR   = 8,
  parameter int DIE_FR    = 16,
  parameter int RESP_FR   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   frame_tick_i,
  input  logic [NUM_ENEMY-1:0]   hit_i,
  input  logic [5*NUM_ENEMY-1:0] pos_i,
  input  logic [9:0]             h_cnt_i,
  input  logic [9:0]             v_cnt_i,
  output logic [NUM_ENEMY-1:0]   alive_o,
  output logic [NUM_ENEMY-1:0]   hit_ack_o,
  output logic                   damage_o,
  output logic [14:0]            pixel_addr_o,
  output logic                   pix_valid_o,
  output logic [7:0]             score_o
);

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_HURT,
    ST_DYING,
    ST_RESPAWN
  } state_e;

  state_e                 state_q [NUM_ENEMY];
  state_e                 state_d [NUM_ENEMY];
  logic [3:0]             hp_q    [NUM_ENEMY];
  logic [3:0]             hp_d    [NUM_ENEMY];
  logic [7:0]             tmr_q   [NUM_ENEMY];
  logic [7:0]             tmr_d   [NUM_ENEMY];

  logic [NUM_ENEMY-1:0]   hit_prev_q;
  logic [NUM_ENEMY-1:0]   hit_ack_q;
  logic                   damage_q;
  logic [7:0]             score_q;
  logic [7:0]             score_d;
  logic [1:0]             fcnt_q;
  logic [14:0]            addr_q;
  logic [14:0]            addr_d;
  logic                   valid_q;
  logic                   valid_d;

  logic [NUM_ENEMY-1:0]   in_win;
  logic [NUM_ENEMY-1:0]   accept;
  logic [NUM_ENEMY-1:0]   vis;
  logic [3:0]             kills;
  logic [8:0]             score_sum;

  logic [9:0]             sel;
  logic [9:0]             lx;
  logic                   in_spr;
  logic                   vis_sel;

  always_comb begin
    in_win = '0;
    accept = '0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      in_win[i] = (pos_i[5*i +: 5] >= 5'(HIT_LO)) && (pos_i[5*i +: 5] <= 5'(HIT_HI));
      accept[i] = hit_i[i] && !hit_prev_q[i] && in_win[i] && (state_q[i] == ST_ALIVE);
    end
  end

  always_comb begin
    kills = '0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      state_d[i] = state_q[i];
      hp_d[i]    = hp_q[i];
      tmr_d[i]   = tmr_q[i];
      unique case (state_q[i])
        ST_ALIVE: begin
          if (accept[i]) begin
            if (hp_q[i] > 4'd1) begin
              hp_d[i]    = hp_q[i] - 4'd1;
              tmr_d[i]   = 8'(HURT_FR);
              state_d[i] = ST_HURT;
            end else begin
              hp_d[i]    = '0;
              tmr_d[i]   = 8'(DIE_FR);
              state_d[i] = ST_DYING;
              kills      = kills + 4'd1;
            end
          end
        end
        ST_HURT: begin
          if (frame_tick_i) begin
            tmr_d[i] = tmr_q[i] - 8'd1;
            if (tmr_q[i] == 8'd1) state_d[i] = ST_ALIVE;
          end
        end
        ST_DYING: begin
          if (frame_tick_i) begin
            tmr_d[i] = tmr_q[i] - 8'd1;
            if (tmr_q[i] == 8'd1) begin
              tmr_d[i]   = 8'(RESP_FR);
              state_d[i] = ST_RESPAWN;
            end
          end
        end
        ST_RESPAWN: begin
          if (frame_tick_i) begin
            tmr_d[i] = tmr_q[i] - 8'd1;
            if (tmr_q[i] == 8'd1) begin
              hp_d[i]    = 4'(HP_INIT);
              state_d[i] = ST_ALIVE;
            end
          end
        end
      endcase
    end
  end

  // Combined kills of one cycle are added together, then clamped.
  always_comb begin
    score_sum = {1'b0, score_q} + 9'(kills);
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_comb begin
    vis     = '0;
    alive_o = '0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      alive_o[i] = (state_q[i] == ST_ALIVE) || (state_q[i] == ST_HURT);
      unique case (state_q[i])
        ST_ALIVE:   vis[i] = 1'b1;
        ST_HURT:    vis[i] = fcnt_q[1];
        ST_DYING:   vis[i] = 1'b1;
        ST_RESPAWN: vis[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel     = h_cnt_i / 10'(COL_W);
    lx      = h_cnt_i - sel * 10'(COL_W);
    in_spr  = (lx < 10'(SPR_W)) && (v_cnt_i < 10'(SPR_H));
    addr_d  = in_spr ? (15'(lx) + 15'(v_cnt_i) * 15'(SPR_W)) : '0;
    vis_sel = 1'b0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      if (sel == 10'(i)) vis_sel = vis[i];
    end
    valid_d = in_spr && vis_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENEMY; i++) begin
        state_q[i] <= ST_ALIVE;
        hp_q[i]    <= 4'(HP_INIT);
        tmr_q[i]   <= '0;
      end
      hit_prev_q <= '0;
      hit_ack_q  <= '0;
      damage_q   <= 1'b0;
      score_q    <= '0;
      fcnt_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENEMY; i++) begin
        state_q[i] <= state_d[i];
        hp_q[i]    <= hp_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
      hit_prev_q <= hit_i;
      hit_ack_q  <= accept;
      damage_q   <= |(hit_i & in_win);
      score_q    <= score_d;
      if (frame_tick_i) fcnt_q <= fcnt_q + 2'd1;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
    end
  end

  assign hit_ack_o    = hit_ack_q;
  assign damage_o     = damage_q;
  assign score_o      = score_q;
  assign pixel_addr_o = addr_q;
  assign pix_valid_o  = valid_q;

endmodule

// File: tb/tb_enemy_lane_ctrl.sv
// tb/tb_enemy_lane_ctrl.sv - directed vector bench for enemy_lane_ctrl
module tb_enemy_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [3:0]  hit;
  logic [19:0] pos;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [3:0]  alive;
  logic [3:0]  hit_ack;
  logic        damage;
  logic [14:0] pixel_addr;
  logic        pix_valid;
  logic [7:0]  score;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0] pos;
    logic       acc;
  } win_vec_t;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [14:0] addr;
    logic        valid;
  } pix_vec_t;

  win_vec_t wv[7];
  pix_vec_t pv[8];

  enemy_lane_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_tick_i (frame_tick),
    .hit_i        (hit),
    .pos_i        (pos),
    .h_cnt_i      (h_cnt),
    .v_cnt_i      (v_cnt),
    .alive_o      (alive),
    .hit_ack_o    (hit_ack),
    .damage_o     (damage),
    .pixel_addr_o (pixel_addr),
    .pix_valid_o  (pix_valid),
    .score_o      (score)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    hit        = '0;
    frame_tick = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [3:0] m, output logic [3:0] ack);
    hit = m;
    tick();
    ack = hit_ack;
    hit = '0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic kill_round(input logic [3:0] m);
    logic [3:0] a;
    pulse(m, a);
    frames(8);
    pulse(m, a);
    frames(8);
    pulse(m, a);
    frames(48);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    int acks;
    int dmg_low;

    wv[0] = '{5'd11, 1'b0};
    wv[1] = '{5'd12, 1'b1};
    wv[2] = '{5'd15, 1'b1};
    wv[3] = '{5'd20, 1'b1};
    wv[4] = '{5'd21, 1'b0};
    wv[5] = '{5'd0,  1'b0};
    wv[6] = '{5'd31, 1'b0};

    pv[0] = '{10'd170,  10'd2,   15'd330,   1'b1};
    pv[1] = '{10'd0,    10'd0,   15'd0,     1'b1};
    pv[2] = '{10'd159,  10'd119, 15'd19199, 1'b1};
    pv[3] = '{10'd160,  10'd10,  15'd1600,  1'b1};
    pv[4] = '{10'd639,  10'd0,   15'd159,   1'b1};
    pv[5] = '{10'd650,  10'd3,   15'd490,   1'b0};
    pv[6] = '{10'd170,  10'd120, 15'd0,     1'b0};
    pv[7] = '{10'd1023, 10'd5,   15'd863,   1'b0};

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    hit        = '0;
    pos        = '0;
    h_cnt      = 10'd700;
    v_cnt      = 10'd500;
    tick();
    check("reset_alive", alive, 4'hF);
    check("reset_ack", hit_ack, 0);
    check("reset_damage", damage, 0);
    check("reset_addr", pixel_addr, 0);
    check("reset_valid", pix_valid, 0);
    check("reset_score", score, 0);

    // hit window table
    for (int i = 0; i < 7; i++) begin
      pos = '0;
      do_reset();
      pos = {15'd0, wv[i].pos};
      hit = 4'b0001;
      tick();
      check($sformatf("win%0d_damage", i), damage, wv[i].acc);
      check($sformatf("win%0d_ack", i), hit_ack, {3'b000, wv[i].acc});
      check($sformatf("win%0d_alive", i), alive, 4'hF);
      hit = '0;
      tick();
      check($sformatf("win%0d_ack_clear", i), hit_ack, 0);
    end

    // pixel path table, all enemies alive
    do_reset();
    for (int i = 0; i < 8; i++) begin
      h_cnt = pv[i].h;
      v_cnt = pv[i].v;
      tick();
      check($sformatf("pix%0d_addr", i), pixel_addr, pv[i].addr);
      check($sformatf("pix%0d_valid", i), pix_valid, pv[i].valid);
    end

    // held hit counts once; damage tracks level
    do_reset();
    pos     = {15'd0, 5'd16};
    hit     = 4'b0001;
    acks    = 0;
    dmg_low = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (hit_ack[0]) acks++;
      if (!damage) dmg_low++;
    end
    check("hold_ack_count", acks, 1);
    check("hold_damage_low_cycles", dmg_low, 0);
    hit = '0;
    tick();
    check("hold_damage_release", damage, 0);

    // full kill/respawn sequence on enemy 0
    do_reset();
    pos = {4{5'd15}};
    pulse(4'b0001, a);
    check("kill_hit1_ack", a, 4'b0001);
    pulse(4'b0001, a);
    check("kill_hurt_ignored", a, 0);
    frames(8);
    pulse(4'b0001, a);
    check("kill_hit2_ack", a, 4'b0001);
    check("kill_hit2_alive", alive, 4'hF);
    frames(8);
    pulse(4'b0001, a);
    check("kill_hit3_ack", a, 4'b0001);
    check("kill_score", score, 1);
    check("kill_alive", alive, 4'b1110);
    pulse(4'b0001, a);
    check("kill_dying_ignored", a, 0);
    frames(47);
    check("kill_respawn_47", alive, 4'b1110);
    frames(1);
    check("kill_respawn_48", alive, 4'hF);
    pulse(4'b0001, a);
    check("respawn_hp_ack", a, 4'b0001);
    check("respawn_hp_alive", alive, 4'hF);
    check("respawn_hp_score", score, 1);

    // acceptance and frame_tick in the same cycle: full timer load
    do_reset();
    pos        = {4{5'd15}};
    hit        = 4'b0001;
    frame_tick = 1'b1;
    tick();
    hit        = '0;
    frame_tick = 1'b0;
    tick();
    frames(7);
    pulse(4'b0001, a);
    check("same_cycle_still_hurt", a, 0);
    frames(1);
    pulse(4'b0001, a);
    check("same_cycle_alive_again", a, 4'b0001);

    // hurt blink follows frame counter bit 1
    do_reset();
    pos   = {4{5'd15}};
    h_cnt = 10'd10;
    v_cnt = 10'd0;
    pulse(4'b0001, a);
    check("blink_fcnt0", pix_valid, 0);
    frames(2);
    check("blink_fcnt2", pix_valid, 1);
    check("blink_addr", pixel_addr, 10);

    // simultaneous kill of enemies 1 and 3
    do_reset();
    pos = {4{5'd15}};
    pulse(4'b1010, a);
    frames(8);
    pulse(4'b1010, a);
    frames(8);
    pulse(4'b1010, a);
    check("dual_ack", a, 4'b1010);
    check("dual_score", score, 2);
    check("dual_alive", alive, 4'b0101);
    h_cnt = 10'd170;
    v_cnt = 10'd2;
    tick();
    check("dual_dying_visible", pix_valid, 1);
    frames(16);
    check("dual_respawn_invisible", pix_valid, 0);
    check("dual_respawn_addr", pixel_addr, 330);

    // score saturation
    do_reset();
    pos = {4{5'd15}};
    for (int r = 0; r < 63; r++) kill_round(4'hF);
    check("sat_252", score, 252);
    kill_round(4'hF);
    check("sat_cross", score, 255);
    kill_round(4'b0001);
    check("sat_hold", score, 255);

    // asynchronous reset in the middle of HURT
    h_cnt = 10'd170;
    v_cnt = 10'd2;
    hit   = 4'b0001;
    tick();
    check("pre_rst_ack", hit_ack, 4'b0001);
    check("pre_rst_damage", damage, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_alive", alive, 4'hF);
    check("mid_rst_ack", hit_ack, 0);
    check("mid_rst_damage", damage, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_addr", pixel_addr, 0);
    check("mid_rst_valid", pix_valid, 0);
    hit   = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
